countdown_timer_bcd: RTL

- Parametrised single-clock BCD countdown timer with start/pause/resume control and runtime preset loading.
- Drops the separate slow-clock domain: an internal prescaler derives the count tick from `clk`.
- Sits between the debounced/one-pulsed push-button logic and the 7-segment/LED display drivers.
- Drives N BCD digits plus an expiry flag and a 16-bit LED bank.

---
 rtl/countdown_timer_bcd_if.sv | 48 ++++
 rtl/countdown_timer_bcd.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_bcd_if.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer_bcd_if
// Purpose  : Control/status bundle between the push-button front end, the
//            BCD countdown timer and the display drivers.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals (DIGITS = number of BCD digits):
//   start_pulse  master->slave  1         start/pause toggle (one cycle)
//   load         master->slave  1         preset load strobe
//   load_value   master->slave  4*DIGITS  packed BCD preset
//   count        slave->master  4*DIGITS  current packed BCD value
//   running      slave->master  1         timer is counting
//   expired      slave->master  1         expiry indication
//   led          slave->master  16        LED bank
// ============================================================================
interface countdown_timer_bcd_if #(
  parameter int DIGITS = 2
);
  logic                  start_pulse;
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic [4*DIGITS-1:0]   count;
  logic                  running;
  logic                  expired;
  logic [15:0]           led;

  modport master (
    output start_pulse,
    output load,
    output load_value,
    input  count,
    input  running,
    input  expired,
    input  led
  );

  modport slave (
    input  start_pulse,
    input  load,
    input  load_value,
    output count,
    output running,
    output expired,
    output led
  );
endinterface
`default_nettype wire

// File: rtl/countdown_timer_bcd.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer_bcd
// Purpose  : Single-clock BCD countdown timer with start/pause/resume and
//            runtime preset loading. An internal prescaler divides clk by
//            TICK_DIV to produce the count tick.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk    in   system clock
//   rst_p  in   asynchronous active-high reset
//   bus    slave modport of countdown_timer_bcd_if
//            start_pulse, load, load_value  (in)
//            count, running, expired, led   (out)
// Parameters:
//   DIGITS      number of BCD digits (1..8)
//   INIT_VALUE  packed BCD reset preset (every nibble <= 9)
//   TICK_DIV    clk cycles per count tick (>= 1)
// Build option:
//   AUTO_RELOAD_EN  when defined, reaching zero in RUN reloads the preset,
//                   stays in RUN and pulses expired for one cycle.
// ============================================================================
module countdown_timer_bcd #(
  parameter int                  DIGITS     = 2,
  parameter logic [4*DIGITS-1:0] INIT_VALUE = 8'h30,
  parameter int                  TICK_DIV   = 100
) (
  input  wire logic            clk,
  input  wire logic            rst_p,
  countdown_timer_bcd_if.slave bus
);

  localparam int               c_W        = 4 * DIGITS;
  localparam int               c_PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_PW-1:0]  c_TICK_MAX = c_PW'(TICK_DIV - 1);
  localparam logic [c_W-1:0]   c_ONE      = c_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_W-1:0]    r_preset;
  logic [c_W-1:0]    w_preset_nxt;
  logic [c_W-1:0]    r_count;
  logic [c_W-1:0]    w_count_nxt;
  logic [c_PW-1:0]   r_presc;
  logic [c_PW-1:0]   w_presc_nxt;
  logic              r_running;
  logic              r_expired;
  logic [15:0]       r_led;
  logic              w_reload;

  logic              w_tick;
  logic              w_count_zero;
  logic              w_count_one;
  logic [c_W-1:0]    w_count_dec;
  logic [c_W-1:0]    w_load_sat;
  // w_borrow[i] = all digits below i are zero; the top bit therefore
  // doubles as the whole-count-is-zero flag.
  logic [DIGITS:0]   w_borrow;

  assign w_borrow[0]  = 1'b1;
  assign w_count_zero = w_borrow[DIGITS];
  assign w_count_one  = (r_count == c_ONE);
  assign w_tick       = (r_state == S_RUN) && (r_presc == c_TICK_MAX);

  // Per-digit BCD decrement with borrow chain, and load-value saturation.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0] w_dig;
    logic [3:0] w_ld;

    assign w_dig = r_count[4*gi +: 4];
    assign w_ld  = bus.load_value[4*gi +: 4];

    assign w_count_dec[4*gi +: 4] = !w_borrow[gi]   ? w_dig :
                                    (w_dig == 4'd0) ? 4'd9  :
                                                      (w_dig - 4'd1);
    assign w_borrow[gi+1]         = w_borrow[gi] & (w_dig == 4'd0);
    assign w_load_sat[4*gi +: 4]  = (w_ld > 4'd9) ? 4'd9 : w_ld;
  end

  // --------------------------------------------------------------------------
  // State / datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      r_state   <= S_IDLE;
      r_preset  <= INIT_VALUE;
      r_count   <= INIT_VALUE;
      r_presc   <= '0;
      r_running <= 1'b0;
      r_expired <= 1'b0;
      r_led     <= 16'h0000;
    end else begin
      r_state   <= w_state_nxt;
      r_preset  <= w_preset_nxt;
      r_count   <= w_count_nxt;
      r_presc   <= w_presc_nxt;
      // Status outputs follow the state being entered so they line up with
      // r_state on every edge.
      r_running <= (w_state_nxt == S_RUN);
`ifdef AUTO_RELOAD_EN
      r_expired <= (w_state_nxt == S_DONE) || w_reload;
      r_led     <= 16'h0000;
`else
      r_expired <= (w_state_nxt == S_DONE) || w_reload;
      r_led     <= (w_state_nxt == S_DONE) ? 16'hFFFF : 16'h0000;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_preset_nxt = r_preset;
    w_count_nxt  = r_count;
    w_reload     = 1'b0;

    // Prescaler runs only in RUN, is frozen in PAUSE, cleared elsewhere.
    case (r_state)
      S_RUN:   w_presc_nxt = w_tick ? '0 : (r_presc + c_PW'(1));
      S_PAUSE: w_presc_nxt = r_presc;
      default: w_presc_nxt = '0;
    endcase

    if (bus.load) begin
      w_preset_nxt = w_load_sat;
      w_count_nxt  = w_load_sat;
      w_presc_nxt  = '0;
      w_state_nxt  = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_pulse) begin
            w_state_nxt = w_count_zero ? S_DONE : S_RUN;
          end
        end

        S_RUN: begin
          // The zero guard keeps the count from ever wrapping to all nines.
          if (w_tick && !w_count_zero) begin
            if (w_count_one) begin
`ifdef AUTO_RELOAD_EN
              w_count_nxt = r_preset;
              w_reload    = 1'b1;
`else
              w_count_nxt = '0;
              w_state_nxt = S_DONE;
`endif
            end else begin
              w_count_nxt = w_count_dec;
            end
          end
          // Expiry wins over a simultaneous pause request.
          if (bus.start_pulse && (w_state_nxt == S_RUN)) begin
            w_state_nxt = S_PAUSE;
          end
        end

        S_PAUSE: begin
          if (bus.start_pulse) begin
            w_state_nxt = S_RUN;
          end
        end

        S_DONE: begin
          if (bus.start_pulse) begin
            w_count_nxt = r_preset;
            w_state_nxt = S_IDLE;
          end
        end

        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign bus.count   = r_count;
  assign bus.running = r_running;
  assign bus.expired = r_expired;
  assign bus.led     = r_led;

endmodule
`default_nettype wire
